// File: rtl/line_buffer_window_3x3.sv
// line_buffer_window_3x3: takes a raster-order pixel stream and produces a
// registered 3x3 neighbourhood for every pixel whose whole window lies inside
// the image. Two line memories hold the previous two rows. Three 3-deep shift
// registers form the window columns. The output register also carries the
// window-centre coordinates and an end-of-frame flag.
module line_buffer_window_3x3 #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = 8,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_p00,
  output logic [PIX_W-1:0] out_p01,
  output logic [PIX_W-1:0] out_p02,
  output logic [PIX_W-1:0] out_p10,
  output logic [PIX_W-1:0] out_p11,
  output logic [PIX_W-1:0] out_p12,
  output logic [PIX_W-1:0] out_p20,
  output logic [PIX_W-1:0] out_p21,
  output logic [PIX_W-1:0] out_p22,
  output logic [RW-1:0]    out_row,
  output logic [CW-1:0]    out_col,
  output logic             out_eof
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic             acc;
  logic [RW-1:0]    row_q, row_d, eff_row;
  logic [CW-1:0]    col_q, col_d, eff_col;
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [PIX_W-1:0] win_q [3][3];
  logic             out_valid_q, out_valid_d;
  logic             out_eof_q;
  logic [RW-1:0]    out_row_q;
  logic [CW-1:0]    out_col_q;

  // A held window blocks input, so a stalled output never loses a pixel.
  assign in_ready = !out_valid_q || out_ready;
  assign acc      = in_valid && in_ready;

  // in_sof forces the accepted pixel to (0,0) no matter where the counters are.
  assign eff_row = in_sof ? '0 : row_q;
  assign eff_col = in_sof ? '0 : col_q;

  // Both line memories are read at the column being written, before the write lands.
  assign lb0_rd = lb0[eff_col];
  assign lb1_rd = lb1[eff_col];

  // Next-position counters and output-valid next state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    if (acc) begin
      if (eff_col == COL_LAST) begin
        col_d = '0;
        row_d = (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
      end else begin
        col_d = eff_col + CW'(1);
        row_d = eff_row;
      end
      out_valid_d = (eff_row >= RW'(2)) && (eff_col >= CW'(2));
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Position counters and output handshake state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      if (acc) begin
        out_row_q <= eff_row - RW'(1);
        out_col_q <= eff_col - CW'(1);
        out_eof_q <= (eff_row == ROW_LAST) && (eff_col == COL_LAST);
      end
    end
  end

  // Line memories: lb0 holds the row above and lb1 the row above that.
  always_ff @(posedge clk) begin
    // NOTE: the memories have no reset; rows 0 and 1 never reach a valid window, so stale contents are harmless.
    if (acc) begin
      lb1[eff_col] <= lb0_rd;
      lb0[eff_col] <= in_pixel;
    end
  end

  // Window shift registers: the three rows shift left, and the new column enters on the right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else if (acc) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb1_rd;
      win_q[1][2] <= lb0_rd;
      win_q[2][2] <= in_pixel;
    end
  end

  assign out_valid = out_valid_q;
  assign out_eof   = out_eof_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_p00   = win_q[0][0];
  assign out_p01   = win_q[0][1];
  assign out_p02   = win_q[0][2];
  assign out_p10   = win_q[1][0];
  assign out_p11   = win_q[1][1];
  assign out_p12   = win_q[1][2];
  assign out_p20   = win_q[2][0];
  assign out_p21   = win_q[2][1];
  assign out_p22   = win_q[2][2];

endmodule
